// File: rtl/seven_seg_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment driver.
// Segments are active-low, bit order seg[6:0] = g f e d c b a.
package seven_seg_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Hex nibble to active-low glyph lookup.
  function automatic logic [6:0] hex_glyph(input digit_t d);
    case (d)
      4'h0:    hex_glyph = GLYPH_0;
      4'h1:    hex_glyph = GLYPH_1;
      4'h2:    hex_glyph = GLYPH_2;
      4'h3:    hex_glyph = GLYPH_3;
      4'h4:    hex_glyph = GLYPH_4;
      4'h5:    hex_glyph = GLYPH_5;
      4'h6:    hex_glyph = GLYPH_6;
      4'h7:    hex_glyph = GLYPH_7;
      4'h8:    hex_glyph = GLYPH_8;
      4'h9:    hex_glyph = GLYPH_9;
      4'hA:    hex_glyph = GLYPH_A;
      4'hB:    hex_glyph = GLYPH_B;
      4'hC:    hex_glyph = GLYPH_C;
      4'hD:    hex_glyph = GLYPH_D;
      4'hE:    hex_glyph = GLYPH_E;
      4'hF:    hex_glyph = GLYPH_F;
      default: hex_glyph = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-to-seven-segment decoder with a blank override.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  digit_t     digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blank wins over the glyph so the caller can dark a digit without touching its value.
  always_comb begin
    seg_o = SEG_BLANK;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = hex_glyph(digit_i);
    end
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed NUM_DIGITS hex display driver: shadow/active digit registers,
// scan and blink timing, leading-zero and blink blanking, registered seg/an pins.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int DAT_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0]      IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]      IDX_ZERO = IDX_W'(0);
  localparam logic [FRM_W-1:0]      FRM_LAST = FRM_W'(BLINK_FRAMES - 1);
  localparam logic [FRM_W-1:0]      FRM_ONE  = FRM_W'(1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);
  localparam logic [NUM_DIGITS-1:0] NZ_NONE  = NUM_DIGITS'(0);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FRM_W-1:0]      frm_q, frm_d;
  logic                  phase_q, phase_d;
  logic [DAT_W-1:0]      shadow_q, shadow_d;
  logic [DAT_W-1:0]      active_q, active_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  digit_t                cur_digit;
  logic [NUM_DIGITS-1:0] nibble_nz;
  logic [NUM_DIGITS-1:0] upper_nz;
  logic                  blank;

  // Scan timing plus shadow capture; the active copy happens only when the index wraps.
  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    frm_d    = frm_q;
    phase_d  = phase_q;
    shadow_d = shadow_q;
    active_d = active_q;
    if (load) begin
      shadow_d = in;
    end else begin
      shadow_d = shadow_q;
    end
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d    = IDX_ZERO;
        active_d = shadow_q;
        if (frm_q == FRM_LAST) begin
          frm_d   = '0;
          phase_d = ~phase_q;
        end else begin
          frm_d   = frm_q + FRM_ONE;
        end
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Select the lit digit and decide whether it is blanked (leading zero or blink off-phase).
  always_comb begin
    cur_digit = active_q[{idx_q, 2'b00} +: 4];
    nibble_nz = NZ_NONE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nibble_nz[i] = |active_q[4*i +: 4];
    end
    upper_nz = nibble_nz >> idx_q;
    blank    = (lz_en && (idx_q != IDX_ZERO) && (upper_nz == NZ_NONE)) ||
               (blink_mask[idx_q] && phase_q);
    an_d     = ~(AN_ONE << idx_q);
  end

  seven_seg_hex_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (blank),
    .seg_o   (seg_d)
  );

  // State and output registers; reset discards any pending shadow data.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= IDX_ZERO;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
      seg_q    <= SEG_BLANK;
      an_q     <= '1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: a timing-arithmetic reference model predicts seg/an after every
// edge; the main process compares each cycle and adds hand-computed literal checks.
module tb_seven_seg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   din = 16'h0000;
  logic          load = 1'b0;
  logic          lz_en = 1'b0;
  logic [3:0]    blink_mask = 4'h0;
  logic [6:0]    seg;
  logic [3:0]    an;

  int checks = 0;
  int failures = 0;

  seven_seg_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (din),
    .load       (load),
    .lz_en      (lz_en),
    .blink_mask (blink_mask),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: e = edges since reset; digit position and frame follow by division.
  int          e = 0;
  int          m_idx;
  int          m_frame;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_active = 16'h0000;
  logic [15:0] m_upper;
  logic        m_blank;
  logic [6:0]  exp_seg = 7'h7F;
  logic [3:0]  exp_an = 4'hF;
  bit          m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      e        = 0;
      m_shadow = 16'h0000;
      m_active = 16'h0000;
      exp_seg  = 7'h7F;
      exp_an   = 4'hF;
    end else begin
      m_idx   = (e / SD) % ND;
      m_frame = e / (SD * ND);
      m_upper = m_active >> (4 * m_idx);
      m_blank = (lz_en && m_idx != 0 && m_upper == 16'h0000) ||
                (blink_mask[m_idx] && ((m_frame / BF) % 2 == 1));
      exp_seg = m_blank ? 7'h7F : glyph[m_upper[3:0]];
      exp_an  = ~(4'b0001 << m_idx);
      if ((e + 1) % (SD * ND) == 0) m_active = m_shadow;
      if (load) m_shadow = din;
      e = e + 1;
    end
    m_valid = 1'b1;
  end

  // Advance one cycle and compare the DUT against the model away from the active edge.
  task automatic step();
    @(negedge clk);
    if (m_valid) begin
      checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        failures++;
        $display("FAIL model t=%0t seg=%b an=%b expected seg=%b an=%b", $time, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic chk(input string name, input logic [6:0] act_seg, input logic [3:0] act_an,
                     input logic [6:0] want_seg, input logic [3:0] want_an);
    checks++;
    if (act_seg !== want_seg || act_an !== want_an) begin
      failures++;
      $display("FAIL %s seg=%b an=%b expected seg=%b an=%b", name, act_seg, act_an, want_seg, want_an);
    end
  endtask

  // Step until an shows the target digit, bounded by a cycle budget.
  task automatic wait_an(input logic [3:0] tgt);
    int n;
    n = 0;
    while (an !== tgt && n < 64) begin
      step();
      n++;
    end
    if (an !== tgt) begin
      checks++;
      failures++;
      $display("FAIL wait_an an=%b expected %b within 64 cycles", an, tgt);
    end
  endtask

  task automatic load_val(input logic [15:0] v);
    din  = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  int lit_cnt;
  int blank_cnt;
  logic [3:0] an_seq [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] s1a2f  [4] = '{7'b0001110, 7'b0100100, 7'b0001000, 7'b1111001};

  initial begin
    // Reset held for three cycles
    repeat (3) step();
    chk("reset", seg, an, 7'h7F, 4'hF);
    rst = 1'b0;
    step();
    chk("first_edge", seg, an, 7'b1000000, 4'hE);

    // Scan and decode of 1A2F: loaded at edge 2, shown during edges 17..32
    din = 16'h1A2F;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (14) step();
    for (int k = 0; k < 16; k++) begin
      step();
      chk("scan_1a2f", seg, an, s1a2f[k / 4], an_seq[k / 4]);
    end

    // Frame coherency: load 1234 mid-frame, old value persists until wrap
    repeat (5) step();
    load_val(16'h1234);
    chk("coherent_old", seg, an, 7'b0100100, 4'hD);
    repeat (11) step();
    chk("coherent_new", seg, an, 7'b0011001, 4'hE);

    // Leading-zero blanking
    lz_en = 1'b1;
    load_val(16'h0050);
    repeat (40) step();
    wait_an(4'h7); chk("lz_d3", seg, an, 7'h7F, 4'h7);
    wait_an(4'hB); chk("lz_d2", seg, an, 7'h7F, 4'hB);
    wait_an(4'hD); chk("lz_d1", seg, an, 7'b0010010, 4'hD);
    wait_an(4'hE); chk("lz_d0", seg, an, 7'b1000000, 4'hE);
    load_val(16'h0000);
    repeat (40) step();
    wait_an(4'h7); chk("lz0_d3", seg, an, 7'h7F, 4'h7);
    wait_an(4'hB); chk("lz0_d2", seg, an, 7'h7F, 4'hB);
    wait_an(4'hD); chk("lz0_d1", seg, an, 7'h7F, 4'hD);
    wait_an(4'hE); chk("lz0_d0", seg, an, 7'b1000000, 4'hE);

    // Blink on digit 0: over 8 frames it is lit in 4 and dark in 4
    lz_en = 1'b0;
    blink_mask = 4'b0001;
    load_val(16'h8888);
    repeat (40) step();
    lit_cnt = 0;
    blank_cnt = 0;
    for (int f = 0; f < 8; f++) begin
      wait_an(4'hD);
      wait_an(4'hE);
      if (seg === 7'b0000000) lit_cnt++;
      else if (seg === 7'h7F) blank_cnt++;
      else lit_cnt = lit_cnt + 100;
    end
    chk("blink_lit", {3'b000, 4'(lit_cnt)}, 4'h0, 7'd4, 4'h0);
    chk("blink_dark", {3'b000, 4'(blank_cnt)}, 4'h0, 7'd4, 4'h0);
    wait_an(4'hD); chk("blink_other", seg, an, 7'b0000000, 4'hD);
    blink_mask = 4'h0;

    // Reset mid-digit after a load
    load_val(16'hABCD);
    repeat (42) step();
    rst = 1'b1;
    step();
    chk("mid_reset", seg, an, 7'h7F, 4'hF);
    rst = 1'b0;
    step();
    chk("post_reset", seg, an, 7'b1000000, 4'hE);
    repeat (20) step();
    wait_an(4'hE); chk("cleared", seg, an, 7'b1000000, 4'hE);

    // Randomized traffic checked cycle-by-cycle by the model
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 7) == 0);
      din  = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
      rst  = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0;
    load = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
